// File: rtl/vga_pattern_pkg.sv
// Shared types for the VGA test-pattern generator: pattern modes, FSM states
// and the colour-bar palette (8-bit channels, R,G,B from MSB).
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_GRAD    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [23:0] BAR_COLOURS [8] = '{
    24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
    24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000
  };

  // Bars are pure primaries, so one bit per channel is enough to rebuild any width.
  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    return {BAR_COLOURS[idx][23], BAR_COLOURS[idx][15], BAR_COLOURS[idx][7]};
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster position counters plus combinational active/sync/frame-start flags
// derived from the current count; counters held at 0 while en_i is low.
module vga_timing_counter #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC_LEN = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC_LEN = 2,
  parameter int V_BP       = 33,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC_LEN + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC_LEN + V_BP,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic [HW-1:0] hcnt_o,
  output logic [VW-1:0] vcnt_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          frame_start_o,
  output logic          last_pixel_o
);

  localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_C  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_START_C = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_C  = HW'(H_ACTIVE + H_FP + H_SYNC_LEN - 1);
  localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_C  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_START_C = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_C  = VW'(V_ACTIVE + V_FP + V_SYNC_LEN - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_last, v_last;

  assign h_last = (hcnt_q == H_LAST_C);
  assign v_last = (vcnt_q == V_LAST_C);

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!en_i) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (h_last) begin
      hcnt_d = '0;
      vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o        = hcnt_q;
  assign vcnt_o        = vcnt_q;
  assign active_o      = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
  assign hsync_o       = (hcnt_q >= HS_START_C) && (hcnt_q <= HS_END_C);
  assign vsync_o       = (vcnt_q >= VS_START_C) && (vcnt_q <= VS_END_C);
  assign frame_start_o = (hcnt_q == '0) && (vcnt_q == '0);
  assign last_pixel_o  = h_last && v_last;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: idle/run FSM, per-frame mode capture, registered outputs
// one clock behind the raster counters. PATTERN_BORDER_EN adds an all-ones frame border.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int DATAWIDTH  = 24,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC_LEN = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC_LEN = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  localparam int CW        = DATAWIDTH / 3,
  localparam int HW        = $clog2(H_ACTIVE + H_FP + H_SYNC_LEN + H_BP),
  localparam int VW        = $clog2(V_ACTIVE + V_FP + V_SYNC_LEN + V_BP)
) (
  input  logic                 REF_CLK,
  input  logic                 RESET,
  input  logic                 CONFIG_DONE,
  input  logic [1:0]           MODE,
  input  logic [DATAWIDTH-1:0] IMAGE_DATA,
  output logic                 H_SYNC,
  output logic                 V_SYNC,
  output logic                 DATA_ENABLE,
  output logic [DATAWIDTH-1:0] PIXEL_DATA,
  output logic                 FRAME_START
);

  localparam logic          SYNC_IDLE = (SYNC_POL == 0);
  localparam logic [HW-1:0] BAR_W_C   = HW'(H_ACTIVE / 8);

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [DATAWIDTH-1:0]   colour_q, colour_d;
  logic                   run;

  logic [HW-1:0]          hcnt;
  logic [VW-1:0]          vcnt;
  logic                   active, hsync_raw, vsync_raw, frame_start_raw, last_pixel;

  logic                   h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic                   de_q, de_d, fs_q, fs_d;
  logic [DATAWIDTH-1:0]   pix_q, pix_d, pattern;

  logic [HW-1:0]          bar_full;
  logic [2:0]             bar_idx, bar_rgb;
  logic [CW-1:0]          grad_val;

  vga_timing_counter #(
    .H_ACTIVE   (H_ACTIVE),
    .H_FP       (H_FP),
    .H_SYNC_LEN (H_SYNC_LEN),
    .H_BP       (H_BP),
    .V_ACTIVE   (V_ACTIVE),
    .V_FP       (V_FP),
    .V_SYNC_LEN (V_SYNC_LEN),
    .V_BP       (V_BP)
  ) u_timing (
    .clk_i         (REF_CLK),
    .rst_ni        (RESET),
    .en_i          (run),
    .hcnt_o        (hcnt),
    .vcnt_o        (vcnt),
    .active_o      (active),
    .hsync_o       (hsync_raw),
    .vsync_o       (vsync_raw),
    .frame_start_o (frame_start_raw),
    .last_pixel_o  (last_pixel)
  );

  assign run = (state_q == ST_RUN);

  // Shutdown is only honoured on the last pixel so a frame is never cut short.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (CONFIG_DONE) state_d = ST_RUN;
      ST_RUN:  if (last_pixel && !CONFIG_DONE) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel (0,0) already uses the newly captured settings, hence the bypass via _d.
  always_comb begin
    mode_d   = mode_q;
    colour_d = colour_q;
    if (run && frame_start_raw) begin
      mode_d   = mode_e'(MODE);
      colour_d = IMAGE_DATA;
    end
  end

  assign bar_full = hcnt / BAR_W_C;
  assign bar_idx  = (bar_full > HW'(7)) ? 3'd7 : bar_full[2:0];
  assign bar_rgb  = bar_mask(bar_idx);
  assign grad_val = CW'(hcnt);

`ifdef PATTERN_BORDER_EN
  logic border;
  assign border = (hcnt == '0) || (hcnt == HW'(H_ACTIVE - 1)) ||
                  (vcnt == '0) || (vcnt == VW'(V_ACTIVE - 1));
`else
  logic unused_vcnt;
  assign unused_vcnt = ^vcnt;
`endif

  always_comb begin
    pattern = '0;
    unique case (mode_d)
      MODE_SOLID:   pattern = colour_d;
      MODE_BARS:    pattern = {{CW{bar_rgb[2]}}, {CW{bar_rgb[1]}}, {CW{bar_rgb[0]}}};
      MODE_CHECKER: pattern = (hcnt[5] ^ vcnt[5]) ? '0 : colour_d;
      MODE_GRAD:    pattern = {3{grad_val}};
      default:      pattern = '0;
    endcase
`ifdef PATTERN_BORDER_EN
    if (border) pattern = '1;
`endif
  end

  assign de_d     = run && active;
  assign fs_d     = run && frame_start_raw;
  assign h_sync_d = SYNC_IDLE ^ (run && hsync_raw);
  assign v_sync_d = SYNC_IDLE ^ (run && vsync_raw);
  assign pix_d    = de_d ? pattern : '0;

  always_ff @(posedge REF_CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_SOLID;
      colour_q <= '0;
      h_sync_q <= SYNC_IDLE;
      v_sync_q <= SYNC_IDLE;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      colour_q <= colour_d;
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
      pix_q    <= pix_d;
    end
  end

  assign H_SYNC      = h_sync_q;
  assign V_SYNC      = v_sync_q;
  assign DATA_ENABLE = de_q;
  assign FRAME_START = fs_q;
  assign PIXEL_DATA  = pix_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen using a reduced raster (336 x 40 total)
// so several complete frames fit in a short run.
module tb_vga_pattern_gen;

  localparam int H_ACT = 320, H_FP = 4, H_SY = 8, H_BP = 4;
  localparam int V_ACT = 34,  V_FP = 1, V_SY = 2, V_BP = 3;
  localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] img = 24'h0;
  logic        hs, vs, de, fs;
  logic [23:0] pix;

  int n_vec = 0;
  int n_bad = 0;
  int since_fs = -1000000;
  int k, de_n, hs_n, vs_n, fs_n, hs_first, vs_first;

  vga_pattern_gen #(
    .DATAWIDTH  (24),
    .H_ACTIVE   (H_ACT),
    .H_FP       (H_FP),
    .H_SYNC_LEN (H_SY),
    .H_BP       (H_BP),
    .V_ACTIVE   (V_ACT),
    .V_FP       (V_FP),
    .V_SYNC_LEN (V_SY),
    .V_BP       (V_BP),
    .SYNC_POL   (0)
  ) dut (
    .REF_CLK     (clk),
    .RESET       (rst_n),
    .CONFIG_DONE (cfg),
    .MODE        (mode),
    .IMAGE_DATA  (img),
    .H_SYNC      (hs),
    .V_SYNC      (vs),
    .DATA_ENABLE (de),
    .PIXEL_DATA  (pix),
    .FRAME_START (fs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; tracks position within the frame.
  task automatic tick();
    @(posedge clk);
    #1;
    if (fs) since_fs = 0;
    else    since_fs++;
  endtask

  task automatic goto(input int x, input int y);
    int tgt = y * H_TOT + x;
    int n = 0;
    while (since_fs != tgt && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("goto", since_fs, tgt);
  endtask

  function automatic logic [23:0] ex(input int x, input int y, input logic [23:0] v);
`ifdef PATTERN_BORDER_EN
    if (x == 0 || x == H_ACT - 1 || y == 0 || y == V_ACT - 1) return 24'hffffff;
`endif
    return v;
  endfunction

  task automatic px(input string tag, input int x, input int y, input logic [23:0] v);
    goto(x, y);
    chk(tag, pix, ex(x, y, v));
  endtask

  task automatic wait_fs();
    k = 0;
    while (!fs && k < 20) begin
      tick();
      k++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_de", de, 1'b0);
    chk("rst_pix", pix, 24'h0);
    chk("rst_hs", hs, 1'b1);
    chk("rst_vs", vs, 1'b1);
    chk("rst_fs", fs, 1'b0);

    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_de", de, 1'b0);
    chk("idle_hs", hs, 1'b1);

    // Startup: solid red, two clocks from CONFIG_DONE to first pixel.
    img = 24'hff0000;
    mode = 2'd0;
    cfg = 1'b1;
    wait_fs();
    chk("start_lat", k, 2);
    chk("start_de", de, 1'b1);
    chk("start_pix", pix, ex(0, 0, 24'hff0000));

    // Frame 1: raster statistics; switch to bars mid-frame.
    de_n = 0; hs_n = 0; vs_n = 0; hs_first = -1; vs_first = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (de) de_n++;
      if (!hs) begin
        hs_n++;
        if (hs_first < 0) hs_first = since_fs;
      end
      if (!vs) begin
        vs_n++;
        if (vs_first < 0) vs_first = since_fs;
      end
      if (since_fs == 10 * H_TOT + 100) begin
        chk("solid_mid", pix, ex(100, 10, 24'hff0000));
        mode = 2'd1;
      end
      if (since_fs == 20 * H_TOT + 200) chk("solid_after_chg", pix, ex(200, 20, 24'hff0000));
      if (since_fs == H_TOT + H_ACT) begin
        chk("blank_de", de, 1'b0);
        chk("blank_pix", pix, 24'h0);
      end
      tick();
    end
    chk("fs_period", fs, 1'b1);
    chk("de_cnt", de_n, H_ACT * V_ACT);
    chk("hs_low", hs_n, H_SY * V_TOT);
    chk("hs_first", hs_first, H_ACT + H_FP);
    chk("vs_low", vs_n, V_SY * H_TOT);
    chk("vs_first", vs_first, (V_ACT + V_FP) * H_TOT);

    // Frame 2: colour bars, 40 pixels wide.
    px("bar0", 0, 0, 24'hffffff);
    px("bar0_end", 39, 1, 24'hffffff);
    px("bar1", 40, 1, 24'hffff00);
    px("bar3", 120, 2, 24'h00ff00);
    px("bar5", 239, 2, 24'hff0000);
    px("bar7", 280, 3, 24'h000000);
    px("bar7_end", 319, 3, 24'h000000);
    goto(10, 5);
    mode = 2'd2;
    img = 24'h123456;
    px("bar1_defer", 50, 6, 24'hffff00);

    // Frame 3: checkerboard of 32x32 tiles.
    px("chk_00", 0, 0, 24'h123456);
    px("chk_x32", 32, 0, 24'h000000);
    px("chk_x32y32", 32, 32, 24'h123456);
    px("chk_y32", 0, 32, 24'h000000);
    mode = 2'd3;

    // Frame 4: gradient, then shutdown request mid-frame.
    px("grad0", 0, 0, 24'h000000);
    px("grad255", 255, 1, 24'hffffff);
    px("grad256", 256, 1, 24'h000000);
    px("grad300", 300, 2, 24'h2c2c2c);
    goto(0, 10);
    cfg = 1'b0;
    px("grad_tail", 319, 33, 24'h3f3f3f);
    chk("tail_de", de, 1'b1);

    de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (de) de_n++;
      if (!hs) hs_n++;
      if (!vs) vs_n++;
      if (fs) fs_n++;
    end
    chk("shut_de", de_n, 0);
    chk("shut_fs", fs_n, 0);
    chk("shut_hs_tail", hs_n, H_SY * (V_TOT - V_ACT + 1));
    chk("shut_vs_tail", vs_n, V_SY * H_TOT);
    chk("shut_hs_idle", hs, 1'b1);

    // Restart, then asynchronous reset in the active area.
    cfg = 1'b1;
    wait_fs();
    chk("restart_lat", k, 2);
    px("restart_grad", 50, 5, 24'h323232);
    rst_n = 1'b0;
    #1;
    chk("async_de", de, 1'b0);
    chk("async_pix", pix, 24'h0);

    tick();
    rst_n = 1'b1;
    wait_fs();
    chk("relaunch_lat", k, 2);

    // Asynchronous reset during a horizontal sync pulse.
    goto(326, 5);
    chk("hs_active", hs, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_hs", hs, 1'b1);
    hs_n = 0; de_n = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!hs) hs_n++;
      if (de) de_n++;
    end
    chk("rst_hold_hs", hs_n, 0);
    chk("rst_hold_de", de_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 24: pixel width, multiple of 3; channel width CW = DATAWIDTH/3, ordered R,G,B from MSB.
REQ-002 The block SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixels.
REQ-003 The block SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines.
REQ-004 The block SHALL have parameter SYNC_POL, default 0: sync active level, 0 = active-low.
REQ-005 The block SHALL have port REF_CLK, input, 1 bit: pixel clock, rising edge.
REQ-006 The block SHALL have port RESET, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port CONFIG_DONE, input, 1 bit: high once the I2C transmitter configuration is complete.
REQ-008 The block SHALL have port MODE, input, 2 bits: 0 solid, 1 colour bars, 2 checkerboard, 3 grey gradient.
REQ-009 The block SHALL have port IMAGE_DATA, input, DATAWIDTH bits: colour used by the solid and checkerboard modes.
REQ-010 The block SHALL have outputs H_SYNC, V_SYNC and DATA_ENABLE, 1 bit each, all registered.
REQ-011 The block SHALL have output PIXEL_DATA, DATAWIDTH bits, registered.
REQ-012 The block SHALL have output FRAME_START, 1 bit: one-cycle pulse aligned with pixel (0,0).

Function
REQ-013 The block SHALL use an FSM with two states: IDLE and RUN.
REQ-014 In IDLE, the counters SHALL be held at 0, outputs SHALL be inactive (DE=0, data=0, syncs at the inactive level), and the FSM SHALL move to RUN when CONFIG_DONE=1 is sampled.
REQ-015 In RUN, hcnt SHALL count 0..H_TOTAL-1 and wrap to 0, where H_TOTAL = sum of the H parameters; vcnt SHALL increment on each hcnt wrap and wrap to 0 after V_TOTAL-1.
REQ-016 The active region SHALL be hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-017 Horizontal sync SHALL be asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vertical sync likewise on vcnt.
REQ-018 All outputs SHALL lag their counter value by exactly 1 REF_CLK cycle; DE, syncs, data and FRAME_START SHALL stay mutually aligned.
REQ-019 MODE and IMAGE_DATA SHALL be captured only when hcnt=0 and vcnt=0 in RUN, so that a mid-frame change takes effect at the next frame.
REQ-020 Colour bars: bar index = x/(H_ACTIVE/8), saturating at 7; bars SHALL be white, yellow, cyan, green, magenta, red, blue, black, each channel all-ones or 0.
REQ-021 Checkerboard: the pixel SHALL be the captured colour when x[5] XOR y[5] = 0, otherwise 0.
REQ-022 Gradient: every channel SHALL equal x[CW-1:0], wrapping modulo 2^CW.
REQ-023 PIXEL_DATA SHALL be 0 whenever DE=0.
REQ-024 CONFIG_DONE SHALL be sampled in RUN only at the last pixel of a frame; if it is 0 there, the FSM SHALL enter IDLE, so no frame is ever truncated.

Reset
REQ-025 RESET low SHALL immediately force IDLE, counters 0, DE=0, FRAME_START=0, PIXEL_DATA=0, syncs at the inactive level, and captured mode 0 with captured colour 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further sync pulse; after release, operation SHALL follow REQ-014.

Configuration
REQ-027 The macro PATTERN_BORDER_EN SHALL control a border overlay:
- When defined: active pixels with x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1 SHALL be all-ones in every mode.
- When undefined: there SHALL be no border logic, and pixels SHALL follow the pattern alone.

Structure
REQ-028 Package vga_pattern_pkg SHALL hold the mode enum (MODE_SOLID, MODE_BARS, MODE_CHECKER, MODE_GRAD) and the 8-entry bar colour table at CW=8.
REQ-029 Sub-module vga_timing_counter SHALL contain hcnt/vcnt, the active flag, raw syncs and the frame-start flag; the top SHALL hold the FSM and the pattern/output registers.

Verification
REQ-030 Timing: with defaults and CONFIG_DONE=1 -> H_SYNC period 800 clocks, low for 96; V_SYNC period 420000 clocks, low for 2 lines; 640 DE-high clocks per active line; 480 active lines.
REQ-031 Startup and latency: CONFIG_DONE rises at cycle N -> FRAME_START and the first DE at cycle N+2 (one cycle for the state change, one for the output register).
REQ-032 Mode change: MODE changes 0 to 1 mid-frame with IMAGE_DATA=24'hff0000 -> the rest of the frame stays solid ff0000; the next frame shows bars with x=0..79 ffffff and x=560..639 000000.
REQ-033 Checker and gradient: at x=32,y=0 -> 0; at x=32,y=32 -> IMAGE_DATA; in gradient mode at x=300 -> 24'h2c2c2c.
REQ-034 Shutdown and reset: CONFIG_DONE drops mid-frame -> the frame completes, then IDLE with no further DE. RESET low mid-line -> all outputs inactive within the same cycle, with no clock edge needed.
REQ-035 Border: with PATTERN_BORDER_EN defined and mode solid 000000 -> row 0, row 479, column 0 and column 639 are ffffff and the interior is 000000.
